// File: rtl/axis_frame_drain_pkg.sv
// Shared types and sizing helpers for the AXI-Stream frame drain.
package axis_frame_drain_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StGap    = 2'd2
  } state_e;

  localparam int unsigned FrameCntW = 16;

  // Gap counter runs 0..gap-1; keep at least one bit so GAP_CYCLES=0 still elaborates.
  function automatic int unsigned gap_cnt_width(input int unsigned gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/axis_frame_drain_skid.sv
// Two-entry registered skid buffer; entry 0 drives the head, entry 1 absorbs one stall.
module axis_skid_2 #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] ent0_q;
  logic [WIDTH-1:0] ent1_q;
  logic [1:0]       cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      unique case (cnt_q)
        2'd0: begin
          if (push) begin
            ent0_q <= push_data;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            ent0_q <= push_data;
          end else if (push) begin
            ent1_q <= push_data;
            cnt_q  <= 2'd2;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            ent0_q <= ent1_q;
            cnt_q  <= 2'd1;
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

  assign head  = ent0_q;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/axis_frame_drain.sv
// Drains an AXI-Stream source into fixed-length tlast-delimited frames with optional idle gap.
module axis_frame_drain
  import axis_frame_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN  = 64,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic                  enable,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [FrameCntW-1:0]  frame_cnt,
  output logic                  busy
);

  localparam int unsigned CntW    = CNT_WIDTH + 1;
  localparam int unsigned GapW    = gap_cnt_width(GAP_CYCLES);
  localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CntW-1:0] FrameLen  = CntW'(FRAME_LEN);
  localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_LEN - 1);

  state_e                 state_q;
  logic [CntW-1:0]        in_cnt_q;
  logic [GapW-1:0]        gap_q;
  logic [FrameCntW-1:0]   frame_cnt_q;

  logic                   skid_full;
  logic                   skid_empty;
  logic [DATA_WIDTH:0]    skid_head;
  logic                   in_hs;
  logic                   out_hs;
  logic                   last_hs;

  // in_cnt saturates at FRAME_LEN until tlast leaves, which blocks frame overlap.
  assign s_axis_tready = (state_q == StStream) && (in_cnt_q < FrameLen) && !skid_full;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = !skid_empty;
  assign {m_axis_tlast, m_axis_tdata} = skid_head;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign last_hs       = out_hs && m_axis_tlast;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = (state_q != StIdle) || !skid_empty;

  axis_skid_2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (async_reset_n),
    .push     (in_hs),
    .push_data({(in_cnt_q == FrameLast), s_axis_tdata}),
    .pop      (out_hs),
    .head     (skid_head),
    .full     (skid_full),
    .empty    (skid_empty)
  );

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q     <= StIdle;
      in_cnt_q    <= '0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (last_hs) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          in_cnt_q <= '0;
          if (enable) begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (last_hs) begin
            in_cnt_q <= '0;
            gap_q    <= '0;
            if (GAP_CYCLES > 0) begin
              state_q <= StGap;
            end else if (!enable) begin
              state_q <= StIdle;
            end
          end else if (in_hs) begin
            in_cnt_q <= in_cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_q == GapW'(GapLast)) begin
            state_q <= enable ? StStream : StIdle;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_drain.sv
// Scoreboard bench: four drain instances (len 4, len 4 + gap 3, len 1, len 256).
module tb_axis_frame_drain;

  localparam int NDut = 4;

  function automatic int unsigned fl_of(input int g);
    case (g)
      0: return 4;
      1: return 4;
      2: return 1;
      default: return 256;
    endcase
  endfunction

  function automatic int unsigned gap_of(input int g);
    return (g == 1) ? 3 : 0;
  endfunction

  function automatic int unsigned min_frames(input int g);
    case (g)
      0: return 2;
      1: return 20;
      2: return 50;
      default: return 2;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDut-1:0] rst_n, en, s_valid, s_ready, m_valid, m_last, m_ready, busy;
  logic [31:0]     s_data [NDut];
  logic [31:0]     m_data [NDut];
  logic [15:0]     fcnt   [NDut];

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    axis_frame_drain #(
      .DATA_WIDTH(32),
      .FRAME_LEN (fl_of(g)),
      .CNT_WIDTH (8),
      .GAP_CYCLES(gap_of(g))
    ) u_dut (
      .clk          (clk),
      .async_reset_n(rst_n[g]),
      .enable       (en[g]),
      .s_axis_tvalid(s_valid[g]),
      .s_axis_tdata (s_data[g]),
      .s_axis_tready(s_ready[g]),
      .m_axis_tvalid(m_valid[g]),
      .m_axis_tdata (m_data[g]),
      .m_axis_tlast (m_last[g]),
      .m_axis_tready(m_ready[g]),
      .frame_cnt    (fcnt[g]),
      .busy         (busy[g])
    );
  end

  // Scoreboard: stimulus pushes {last, data} per accepted sample, monitor pops per output beat.
  logic [32:0] exp_q [NDut][$];
  int          k [NDut];

  logic chk_ready, chk_idle, exact_gap, final_chk, rand_bp;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int g, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h, required %0h", name, g, got, exp);
  endtask

  // Monitor model state.
  int          occ   [NDut];
  int          inf   [NDut];
  int          gap_n [NDut];
  logic [15:0] efc   [NDut];
  logic [32:0] prev  [NDut];
  logic [NDut-1:0] gap_on = '0;
  logic [NDut-1:0] stall  = '0;

  always @(negedge clk) begin
    logic [32:0] w;
    for (int g = 0; g < NDut; g++) begin
      if (!rst_n[g]) begin
        chk("reset_outputs", g,
            {s_ready[g], m_valid[g], m_last[g], busy[g], m_data[g], fcnt[g]}, '0);
        occ[g] = 0; inf[g] = 0; gap_n[g] = 0; efc[g] = '0;
        gap_on[g] = 1'b0; stall[g] = 1'b0;
        exp_q[g].delete();
      end else begin
        chk("tvalid", g, m_valid[g], occ[g] != 0);
        chk("frame_cnt", g, fcnt[g], efc[g]);
        if (stall[g]) chk("hold", g, {m_valid[g], m_last[g], m_data[g]}, {1'b1, prev[g]});
        if (chk_ready && g == 0) begin
          chk("s_tready", g, s_ready[g], (inf[g] < fl_of(g)) && (occ[g] < 2));
          chk("busy_stream", g, busy[g], 1'b1);
        end
        if (chk_idle && g == 0) begin
          chk("idle_busy", g, busy[g], 1'b0);
          chk("idle_tready", g, s_ready[g], 1'b0);
        end
        if (final_chk) chk("frames_seen", g, fcnt[g] >= 16'(min_frames(g)), 1'b1);
        if (gap_on[g]) begin
          if (m_valid[g]) begin
            if (gap_of(g) == 0 && (g != 0 || exact_gap)) chk("bubble", g, gap_n[g], 1);
            else chk("gap_min", g, gap_n[g] >= int'(gap_of(g) + 1), 1'b1);
            gap_on[g] = 1'b0;
          end else begin
            gap_n[g]++;
          end
        end
        if (m_valid[g] && m_ready[g]) begin
          if (exp_q[g].size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_output dut%0d: got %0h, required no output", g,
                     m_data[g]);
          end else begin
            w = exp_q[g].pop_front();
            chk("sample", g, {m_last[g], m_data[g]}, w);
          end
          if (m_last[g]) begin
            efc[g]++;
            inf[g] = 0;
            gap_on[g] = 1'b1;
            gap_n[g] = 0;
          end
          occ[g]--;
        end
        if (s_valid[g] && s_ready[g]) begin
          inf[g]++;
          occ[g]++;
        end
        stall[g] = m_valid[g] && !m_ready[g];
        prev[g]  = {m_last[g], m_data[g]};
      end
    end
  end

  task automatic step();
    logic [NDut-1:0] hs;
    @(negedge clk);
    for (int g = 0; g < NDut; g++) begin
      hs[g] = rst_n[g] && s_valid[g] && s_ready[g];
      if (hs[g]) exp_q[g].push_back({(k[g] == int'(fl_of(g)) - 1), s_data[g]});
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < NDut; g++) begin
      if (hs[g]) begin
        s_data[g] = s_data[g] + 32'd1;
        k[g] = (k[g] + 1) % int'(fl_of(g));
      end
    end
    if (rand_bp) begin
      m_ready[0] = 1'($urandom_range(0, 1));
      m_ready[2] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_k(input int g, input int val);
    for (int i = 0; i < 40; i++) begin
      if (k[g] == val) return;
      step();
    end
    $display("FAIL wait_in_frame dut%0d: count %0d, required %0d", g, k[g], val);
    $fatal(1, "bench aborted: source stalled");
  endtask

  initial begin
    rst_n = '1; en = '0; s_valid = '0; m_ready = '1;
    chk_ready = 0; chk_idle = 0; exact_gap = 0; final_chk = 0; rand_bp = 0;
    for (int g = 0; g < NDut; g++) begin
      s_data[g] = '0;
      k[g] = 0;
    end
    #1 rst_n = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = '1;
    step();

    // Continuous flow, ready always high.
    en = '1; s_valid = '1; exact_gap = 1;
    repeat (20) step();

    // Random backpressure on the len-4 and len-1 instances.
    rand_bp = 1; chk_ready = 1;
    repeat (600) step();
    rand_bp = 0; m_ready = '1; chk_ready = 0;
    step();
    exact_gap = 0;

    // Drop enable after sample 1: frame must still complete.
    wait_k(0, 2);
    en[0] = 1'b0;
    repeat (12) step();
    chk_idle = 1;
    step();
    chk_idle = 0;

    // Reset mid-frame, between clock edges.
    en[0] = 1'b1;
    wait_k(0, 2);
    #2 rst_n[0] = 1'b0;
    k[0] = 0;
    repeat (2) step();
    rst_n[0] = 1'b1;
    repeat (20) step();

    final_chk = 1;
    step();
    final_chk = 0;
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
